// File: rtl/sd_multi_sector_xfer_ctrl.sv
// UART<->SD multi-sector transfer controller: packs UART bytes into words, writes/reads back sectors
// and streams readback to the UART TX. Optional macro TX_GAP_EN selects fixed-rate TX pacing.
module sd_multi_sector_xfer_ctrl #(
   parameter int unsigned SECTOR_WORDS = 256,
   parameter int unsigned NUM_SECTORS  = 1,
   parameter logic [31:0] BASE_ADDR    = 32'd1000,
   parameter int unsigned RX_DEPTH     = 512,
   parameter int unsigned TX_GAP       = 60000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        init_end,
   input  logic        rx_flag,
   input  logic [7:0]  rx_data,
   input  logic        wr_req,
   input  logic        wr_busy,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [15:0] wr_data,
   input  logic        rd_data_en,
   input  logic [15:0] rd_data,
   input  logic        rd_busy,
   output logic        rd_en,
   output logic [31:0] rd_addr,
   input  logic        tx_ready,
   output logic        tx_flag,
   output logic [7:0]  tx_data,
   output logic        done,
   output logic        err_ovf
);

   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int SW_AW = $clog2(SECTOR_WORDS);
   localparam logic [RX_AW:0] RX_FULL   = (RX_AW + 1)'(RX_DEPTH);
   localparam logic [RX_AW:0] RX_SECTOR = (RX_AW + 1)'(SECTOR_WORDS);
   localparam logic [SW_AW:0] RB_FULL   = (SW_AW + 1)'(SECTOR_WORDS);
   localparam logic [SW_AW:0] LAST_BYTE = (SW_AW + 1)'(2 * SECTOR_WORDS - 1);
   localparam logic [15:0]    IDX_LAST  = 16'(NUM_SECTORS - 1);

   typedef enum logic [2:0] {
      S_FILL,
      S_WR_WAIT,
      S_RD_WAIT,
      S_SEND,
      S_NEXT
   } state_t;

   state_t            state, state_nxt;
   logic              wr_en_nxt, rd_en_nxt, done_nxt;
   logic              enter_rd, enter_send, send_fire, tx_ok;
   logic              wr_busy_d, rd_busy_d;
   logic [15:0]       idx;
   logic [31:0]       sector_addr;

   logic [15:0]       rx_mem [RX_DEPTH];
   logic [RX_AW-1:0]  rx_wp, rx_rp;
   logic [RX_AW:0]    rx_cnt;
   logic [7:0]        rx_hi;
   logic              rx_phase;
   logic              rx_push_req, rx_push, rx_pop;

   logic [15:0]       rb_mem [SECTOR_WORDS];
   logic [SW_AW:0]    rb_cnt;
   logic [SW_AW:0]    byte_cnt;
   logic              rb_push, rb_ovf;
   logic [15:0]       rb_word;
   logic [7:0]        tx_byte;

   // Second byte of each pair completes a word; a full buffer drops it.
   assign rx_push_req = rx_flag && rx_phase;
   assign rx_push     = rx_push_req && (rx_cnt != RX_FULL);
   assign rx_pop      = wr_req && (rx_cnt != '0);
   assign wr_data     = rx_mem[rx_rp];

   assign rb_push = (state == S_RD_WAIT) && rd_data_en && (rb_cnt != RB_FULL);
   assign rb_ovf  = (state == S_RD_WAIT) && rd_data_en && (rb_cnt == RB_FULL);

   assign sector_addr = BASE_ADDR + 32'(idx);
   assign wr_addr     = sector_addr;
   assign rd_addr     = sector_addr;

   // NOTE: buffer storage carries no reset; emptiness lives in the pointers and counts,
   // so a reset discards contents without clearing every entry.
   always_ff @(posedge sys_clk) begin
      if (rx_push)
         rx_mem[rx_wp] <= {rx_hi, rx_data};
      if (rb_push)
         rb_mem[rb_cnt[SW_AW-1:0]] <= rd_data;
   end

   // Missing readback words read out as zero bytes.
   always_comb begin
      rb_word = rb_mem[byte_cnt[SW_AW:1]];
      tx_byte = 8'h00;
      if ({1'b0, byte_cnt[SW_AW:1]} < rb_cnt)
         tx_byte = byte_cnt[0] ? rb_word[7:0] : rb_word[15:8];
   end

`ifdef TX_GAP_EN
   localparam int GAP_W = $clog2(TX_GAP);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TX_GAP - 1);

   logic [GAP_W-1:0] gap_cnt;
   logic             unused_cfg;

   assign unused_cfg = tx_ready;
   assign tx_ok      = (state == S_SEND) && (gap_cnt == GAP_LAST);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)
         gap_cnt <= '0;
      else if (enter_send || tx_ok)
         gap_cnt <= '0;
      else if (state == S_SEND)
         gap_cnt <= gap_cnt + 1'b1;
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^TX_GAP;
   // Blocking on the previous registered flag keeps pulses at least two cycles apart.
   assign tx_ok      = (state == S_SEND) && tx_ready && !tx_flag;
`endif

   // NOTE: every output of this block gets a default before the case statement so that
   // no path leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt  = state;
      wr_en_nxt  = 1'b0;
      rd_en_nxt  = 1'b0;
      done_nxt   = 1'b0;
      enter_rd   = 1'b0;
      enter_send = 1'b0;
      send_fire  = 1'b0;
      case (state)
         S_FILL: begin
            if (rx_cnt >= RX_SECTOR && init_end) begin
               state_nxt = S_WR_WAIT;
               wr_en_nxt = 1'b1;
            end
         end
         S_WR_WAIT: begin
            if (wr_busy_d && !wr_busy) begin
               state_nxt = S_RD_WAIT;
               rd_en_nxt = 1'b1;
               enter_rd  = 1'b1;
            end
         end
         S_RD_WAIT: begin
            if (rd_busy_d && !rd_busy) begin
               state_nxt  = S_SEND;
               enter_send = 1'b1;
            end
         end
         S_SEND: begin
            if (tx_ok) begin
               send_fire = 1'b1;
               if (byte_cnt == LAST_BYTE)
                  state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            state_nxt = S_FILL;
            done_nxt  = (idx == IDX_LAST);
         end
         default: state_nxt = S_FILL;
      endcase
   end

   // NOTE: all state and output registers below use non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state     <= S_FILL;
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         done      <= 1'b0;
         tx_flag   <= 1'b0;
         tx_data   <= 8'h00;
         err_ovf   <= 1'b0;
         wr_busy_d <= 1'b0;
         rd_busy_d <= 1'b0;
         idx       <= '0;
         rx_wp     <= '0;
         rx_rp     <= '0;
         rx_cnt    <= '0;
         rx_hi     <= 8'h00;
         rx_phase  <= 1'b0;
         rb_cnt    <= '0;
         byte_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         wr_en     <= wr_en_nxt;
         rd_en     <= rd_en_nxt;
         done      <= done_nxt;
         tx_flag   <= send_fire;
         tx_data   <= send_fire ? tx_byte : 8'h00;
         wr_busy_d <= wr_busy;
         rd_busy_d <= rd_busy;

         if ((rx_push_req && !rx_push) || rb_ovf)
            err_ovf <= 1'b1;

         if (rx_flag) begin
            if (!rx_phase)
               rx_hi <= rx_data;
            rx_phase <= !rx_phase;
         end
         if (rx_push)
            rx_wp <= rx_wp + 1'b1;
         if (rx_pop)
            rx_rp <= rx_rp + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + 1'b1;
            2'b01:   rx_cnt <= rx_cnt - 1'b1;
            default: rx_cnt <= rx_cnt;
         endcase

         if (enter_rd) begin
            rb_cnt   <= '0;
            byte_cnt <= '0;
         end else begin
            if (rb_push)
               rb_cnt <= rb_cnt + 1'b1;
            if (send_fire)
               byte_cnt <= byte_cnt + 1'b1;
         end

         if (state == S_NEXT)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

endmodule
